// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and sequencing.
// Turns debounced button pulses and a 100 Hz tick into counter strobes,
// stores up to NLAPS lap times, and picks the value shown on the display:
// the live count, a frozen split, or a stored lap under review.
module stopwatch_ctrl #(
  parameter int NLAPS      = 4,
  parameter int HOLD_TICKS = 200,
  parameter int CW         = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     btn_ss,
  input  logic                     btn_lap,
  input  logic                     btn_view,
  input  logic [CW-1:0]            cnt_val,
  output logic                     cnt_inc,
  output logic                     cnt_clr,
  output logic [CW-1:0]            disp_val,
  output logic                     disp_lap,
  output logic [$clog2(NLAPS)-1:0] lap_idx,
  output logic [$clog2(NLAPS):0]   lap_cnt,
  output logic                     lap_full,
  output logic                     running
);

  localparam int LW = $clog2(NLAPS);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [LW:0]   LAP_MAX   = (LW+1)'(NLAPS);
  localparam logic [LW:0]   LAP_ONE   = (LW+1)'(1);
  localparam logic [LW-1:0] IDX_ONE   = LW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_VIEW
  } state_t;

  state_t          state, state_n;
  logic            ret, ret_n;         // 1: VIEW returns to PAUSE, 0: to IDLE
  logic [HW-1:0]   hold, hold_n;       // remaining split-freeze ticks
  logic [LW-1:0]   idx_n;
  logic [LW:0]     lcnt_n;
  logic            cap;                // capture cnt_val into the next lap slot
  logic            inc_n, clr_n;
  logic [CW-1:0]   dval_n;
  logic            dlap_n;

  logic [CW-1:0]   laps [NLAPS];

  // Only the highest-priority button of a cycle is acted on.
  logic ss, lap, view;
  assign ss   = btn_ss;
  assign lap  = btn_lap & ~btn_ss;
  assign view = btn_view & ~btn_ss & ~btn_lap;

  logic view_last;
  assign view_last = (({1'b0, lap_idx} + LAP_ONE) == lap_cnt);

  // Next-state, lap bookkeeping, hold countdown and registered-output values.
  always_comb begin
    state_n = state;
    ret_n   = ret;
    hold_n  = hold;
    idx_n   = lap_idx;
    lcnt_n  = lap_cnt;
    cap     = 1'b0;
    clr_n   = 1'b0;
    inc_n   = (state == S_RUN) && tick;
    dval_n  = cnt_val;
    dlap_n  = 1'b0;

    if (tick && (hold != '0)) begin
      hold_n = hold - HOLD_ONE;
    end

    unique case (state)
      S_IDLE: begin
        if (ss) begin
          state_n = S_RUN;
        end else if (view && (lap_cnt != '0)) begin
          state_n = S_VIEW;
          idx_n   = '0;
          ret_n   = 1'b0;
        end
      end

      S_RUN: begin
        if (ss) begin
          state_n = S_PAUSE;
          hold_n  = '0;
        end else if (lap && (lap_cnt != LAP_MAX)) begin
          // A capture during an active hold simply reloads it.
          cap    = 1'b1;
          lcnt_n = lap_cnt + LAP_ONE;
          hold_n = HOLD_LOAD;
        end
      end

      S_PAUSE: begin
        if (ss) begin
          state_n = S_RUN;
        end else if (lap) begin
          clr_n   = 1'b1;
          lcnt_n  = '0;
          state_n = S_IDLE;
        end else if (view && (lap_cnt != '0)) begin
          state_n = S_VIEW;
          idx_n   = '0;
          ret_n   = 1'b1;
        end
      end

      S_VIEW: begin
        if (lap) begin
          state_n = ret ? S_PAUSE : S_IDLE;
          idx_n   = '0;
        end else if (view) begin
          if (view_last) begin
            state_n = ret ? S_PAUSE : S_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = lap_idx + IDX_ONE;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Display source is decided from the next state so that it lines up with
    // the state change in the same cycle.
    if (state_n == S_VIEW) begin
      dval_n = laps[idx_n];
      dlap_n = 1'b1;
    end else if (cap) begin
      dval_n = cnt_val;
      dlap_n = 1'b1;
    end else if (hold_n != '0) begin
      dval_n = disp_val;
      dlap_n = 1'b1;
    end
  end

  // Control state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ret      <= 1'b0;
      hold     <= '0;
      cnt_inc  <= 1'b0;
      cnt_clr  <= 1'b0;
      disp_val <= '0;
      disp_lap <= 1'b0;
      lap_idx  <= '0;
      lap_cnt  <= '0;
      lap_full <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      hold     <= hold_n;
      cnt_inc  <= inc_n;
      cnt_clr  <= clr_n;
      disp_val <= dval_n;
      disp_lap <= dlap_n;
      lap_idx  <= idx_n;
      lap_cnt  <= lcnt_n;
      lap_full <= (lcnt_n == LAP_MAX);
      running  <= (state_n == S_RUN);
    end
  end

  // Lap storage; contents are left stale on clear since lap_cnt gates reads.
  always_ff @(posedge clk) begin
    if (!rst && cap) begin
      laps[lap_cnt[LW-1:0]] <= cnt_val;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios followed by
// randomized button/tick traffic, all compared against a lap-queue model.
module tb_stopwatch_ctrl;
  localparam int NLAPS      = 4;
  localparam int HOLD_TICKS = 200;
  localparam int CW         = 27;
  localparam int LW         = $clog2(NLAPS);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_VIEW  = 3;

  logic          clk = 1'b0;
  logic          rst, tick, btn_ss, btn_lap, btn_view;
  logic [CW-1:0] cnt_val, disp_val;
  logic          cnt_inc, cnt_clr, disp_lap, lap_full, running;
  logic [LW-1:0] lap_idx;
  logic [LW:0]   lap_cnt;

  stopwatch_ctrl #(.NLAPS(NLAPS), .HOLD_TICKS(HOLD_TICKS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .btn_view(btn_view), .cnt_val(cnt_val), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr),
    .disp_val(disp_val), .disp_lap(disp_lap), .lap_idx(lap_idx), .lap_cnt(lap_cnt),
    .lap_full(lap_full), .running(running)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: mode, lap queue, hold ticks left, review position.
  int            mode, back, pos, hold;
  logic [CW-1:0] laps[$];
  logic [CW-1:0] frozen;
  logic          e_inc, e_clr, e_dl, e_full, e_run;
  logic [CW-1:0] e_dv;
  int            e_idx, e_lc;
  bit            armed = 0;
  int            inc_seen = 0;

  task automatic model_update();
    if (rst) begin
      mode = M_IDLE; back = M_IDLE; pos = 0; hold = 0; laps.delete(); frozen = '0;
      e_inc = 0; e_clr = 0; e_dv = '0; e_dl = 0; e_idx = 0; e_lc = 0; e_full = 0; e_run = 0;
      return;
    end
    e_inc = (mode == M_RUN) && tick;
    e_clr = 0;
    if (tick && hold > 0) hold--;
    if (btn_ss) begin
      if (mode == M_IDLE || mode == M_PAUSE) mode = M_RUN;
      else if (mode == M_RUN) begin mode = M_PAUSE; hold = 0; end
    end else if (btn_lap) begin
      if (mode == M_RUN) begin
        if (laps.size() < NLAPS) begin
          laps.push_back(cnt_val); frozen = cnt_val; hold = HOLD_TICKS;
        end
      end else if (mode == M_PAUSE) begin
        e_clr = 1; laps.delete(); mode = M_IDLE;
      end else if (mode == M_VIEW) begin
        mode = back; pos = 0;
      end
    end else if (btn_view) begin
      if ((mode == M_IDLE || mode == M_PAUSE) && laps.size() > 0) begin
        back = mode; mode = M_VIEW; pos = 0;
      end else if (mode == M_VIEW) begin
        pos++;
        if (pos == laps.size()) begin mode = back; pos = 0; end
      end
    end
    if (mode == M_VIEW) begin
      e_dv = laps[pos]; e_dl = 1;
    end else if (hold > 0) begin
      e_dv = frozen; e_dl = 1;
    end else begin
      e_dv = cnt_val; e_dl = 0;
    end
    e_idx  = pos;
    e_lc   = laps.size();
    e_full = (laps.size() == NLAPS);
    e_run  = (mode == M_RUN);
  endtask

  // One cycle: check the outputs produced by the previous inputs, then drive new ones.
  task automatic step(input bit r, input bit ss, input bit lp, input bit vw,
                      input bit tk, input logic [CW-1:0] cv);
    @(negedge clk);
    if (armed) begin
      check("cnt_inc",  32'(cnt_inc),  32'(e_inc));
      check("cnt_clr",  32'(cnt_clr),  32'(e_clr));
      check("disp_val", 32'(disp_val), 32'(e_dv));
      check("disp_lap", 32'(disp_lap), 32'(e_dl));
      check("lap_idx",  32'(lap_idx),  32'(e_idx));
      check("lap_cnt",  32'(lap_cnt),  32'(e_lc));
      check("lap_full", 32'(lap_full), 32'(e_full));
      check("running",  32'(running),  32'(e_run));
    end
    if (cnt_inc) inc_seen++;
    rst = r; btn_ss = ss; btn_lap = lp; btn_view = vw; tick = tk; cnt_val = cv;
    model_update();
    armed = 1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, CW'($urandom));
  endtask

  logic [CW-1:0] last_cap;

  initial begin
    rst = 1; tick = 0; btn_ss = 0; btn_lap = 0; btn_view = 0; cnt_val = '0;
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    idle();
    check("reset_flags", 32'({running, cnt_inc, cnt_clr, disp_lap, lap_full}), 32'd0);
    check("reset_disp", 32'(disp_val), 32'd0);

    // Start, five ticks, stop.
    step(0, 1, 0, 0, 0, CW'($urandom));
    idle();
    check("run_after_ss", 32'(running), 32'd1);
    inc_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, CW'($urandom));
      idle();
    end
    step(0, 1, 0, 0, 0, CW'($urandom));
    idle();
    idle();
    check("inc_pulses", 32'(inc_seen), 32'd5);
    check("paused", 32'(running), 32'd0);

    // Lap capture of 1234 and full hold duration.
    step(0, 1, 0, 0, 0, CW'($urandom));
    step(0, 0, 1, 0, 0, CW'(1234));
    idle();
    check("split_val", 32'(disp_val), 32'd1234);
    check("split_flag", 32'(disp_lap), 32'd1);
    check("split_cnt", 32'(lap_cnt), 32'd1);
    for (int i = 0; i < HOLD_TICKS - 1; i++) step(0, 0, 0, 0, 1, CW'($urandom));
    idle();
    check("hold_last", 32'(disp_lap), 32'd1);
    step(0, 0, 0, 0, 1, CW'($urandom));
    idle();
    check("hold_release", 32'(disp_lap), 32'd0);

    // Fill the lap store, then one extra press.
    for (int i = 0; i < 3; i++) begin
      last_cap = CW'(5000 + i);
      step(0, 0, 1, 0, 0, last_cap);
      idle();
    end
    check("full_flag", 32'(lap_full), 32'd1);
    step(0, 0, 1, 0, 0, CW'(999));
    idle();
    check("full_cnt", 32'(lap_cnt), 32'(NLAPS));
    check("full_disp", 32'(disp_val), 32'(last_cap));

    // Pause, clear, run, three laps, pause, review four times.
    step(0, 1, 0, 0, 0, CW'($urandom));
    step(0, 0, 1, 0, 0, CW'($urandom));
    idle();
    check("clr_pulse", 32'(cnt_clr), 32'd1);
    idle();
    check("clr_once", 32'(cnt_clr), 32'd0);
    step(0, 1, 0, 0, 0, CW'($urandom));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, CW'(700 + i));
    step(0, 1, 0, 0, 0, CW'($urandom));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, CW'($urandom));
      idle();
      if (i < 3) begin
        check("view_idx", 32'(lap_idx), 32'(i));
        check("view_val", 32'(disp_val), 32'(700 + i));
      end
    end
    check("view_exit", 32'(disp_lap), 32'd0);

    // Clear from pause, then a review press with no laps is ignored.
    step(0, 0, 1, 0, 0, CW'($urandom));
    idle();
    check("clr_cnt", 32'(lap_cnt), 32'd0);
    step(0, 0, 0, 1, 0, CW'($urandom));
    idle();
    check("view_empty", 32'(disp_lap), 32'd0);

    // Start/stop beats lap in the same cycle; reset during a hold.
    step(0, 1, 0, 0, 0, CW'($urandom));
    step(0, 1, 1, 0, 0, CW'($urandom));
    idle();
    check("prio_cnt", 32'(lap_cnt), 32'd0);
    check("prio_run", 32'(running), 32'd0);
    step(0, 1, 0, 0, 0, CW'($urandom));
    step(0, 0, 1, 0, 0, CW'($urandom));
    step(0, 0, 0, 0, 1, CW'($urandom));
    step(1, 0, 0, 0, 1, CW'($urandom));
    idle();
    check("rst_hold", 32'({running, cnt_inc, cnt_clr, disp_lap, lap_full}), 32'd0);
    check("rst_cnt", 32'(lap_cnt), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 0),
           CW'($urandom));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
